minesweeper_ctrl: RTL and testbench

Sequential game controller for the minesweeper `board` datapath. It holds the bomb, reveal and cursor grid registers, drives the `board` inputs, and accepts move/reveal requests from the button front end. It sequences cursor movement, cell reveal, zero-cell flood fill and win/lose detection. It sits between the debounced button logic and the `board` instance, and feeds the display logic.

---
 rtl/minesweeper_ctrl.sv | 136 +++++++++++++
 tb/tb_minesweeper_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minesweeper_ctrl.sv
// Minesweeper game controller: owns the bomb, reveal and cursor grids, and
// sequences cursor moves, reveals, zero-cell flood fill and win/lose detection.
module minesweeper_ctrl #(
    parameter int  GRID_SIZE  = 3,
    parameter int  STATE_SIZE = 4,
    localparam int N          = GRID_SIZE * GRID_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [N-1:0]            bombInit,
    input  logic                    moveReq,
    input  logic [1:0]              moveDir,
    input  logic                    revealReq,
    input  logic [STATE_SIZE*N-1:0] states,
    input  logic [N-1:0]            nextCursorGrid,
    output logic [N-1:0]            bombGrid,
    output logic [N-1:0]            revealGrid,
    output logic [N-1:0]            cursorGrid,
    output logic                    move,
    output logic [1:0]              dir,
    output logic                    ready,
    output logic [2:0]              gameState,
    output logic [7:0]              moveCount
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PLAY   = 3'd1,
        MOVE   = 3'd2,
        REVEAL = 3'd3,
        FLOOD  = 3'd4,
        CHECK  = 3'd5,
        WIN    = 3'd6,
        LOSE   = 3'd7
    } state_t;

    state_t       state_reg;
    logic [N-1:0] zero_mask;
    logic [N-1:0] seed;
    logic [N-1:0] expand;
    logic         cursor_bomb;
    logic         cursor_zero;
    logic         all_clear;

    assign seed = revealGrid & zero_mask;

    // Neighbour wiring is resolved at elaboration; off-grid neighbours tie to 0,
    // so the flood never wraps around an edge.
    for (genvar gi = 0; gi < N; gi++) begin : g_cell
        logic [8:0] nbr;
        assign zero_mask[gi] = (states[gi*STATE_SIZE +: STATE_SIZE] == '0);
        for (genvar gd = 0; gd < 9; gd++) begin : g_nbr
            localparam int NR = gi / GRID_SIZE + gd / 3 - 1;
            localparam int NC = gi % GRID_SIZE + gd % 3 - 1;
            if (gd != 4 && NR >= 0 && NR < GRID_SIZE && NC >= 0 && NC < GRID_SIZE) begin : g_in
                assign nbr[gd] = seed[NR*GRID_SIZE + NC];
            end else begin : g_out
                assign nbr[gd] = 1'b0;
            end
        end
        assign expand[gi] = ~revealGrid[gi] & ~bombGrid[gi] & (|nbr);
    end

    assign cursor_bomb = |(cursorGrid & bombGrid);
    assign cursor_zero = |(cursorGrid & zero_mask);
    assign all_clear   = &(revealGrid | bombGrid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            bombGrid   <= '0;
            revealGrid <= '0;
            cursorGrid <= '0;
            dir        <= 2'b00;
            moveCount  <= 8'd0;
        end else begin
            case (state_reg)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        bombGrid   <= bombInit;
                        revealGrid <= '0;
                        cursorGrid <= {{(N-1){1'b0}}, 1'b1};
                        moveCount  <= 8'd0;
                        state_reg  <= PLAY;
                    end
                end
                PLAY: begin
                    // A simultaneous move request is dropped in favour of the reveal.
                    if (revealReq) begin
                        state_reg <= REVEAL;
                    end else if (moveReq) begin
                        dir       <= moveDir;
                        state_reg <= MOVE;
                    end
                end
                MOVE: begin
                    if (nextCursorGrid != '0) begin
                        cursorGrid <= nextCursorGrid;
                        if (moveCount != 8'hFF) begin
                            moveCount <= moveCount + 8'd1;
                        end
                    end
                    state_reg <= PLAY;
                end
                REVEAL: begin
                    if (cursor_bomb) begin
                        revealGrid <= '1;
                        state_reg  <= LOSE;
                    end else begin
                        revealGrid <= revealGrid | cursorGrid;
                        state_reg  <= cursor_zero ? FLOOD : CHECK;
                    end
                end
                FLOOD: begin
                    if (expand != '0) begin
                        revealGrid <= revealGrid | expand;
                    end else begin
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    state_reg <= all_clear ? WIN : PLAY;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign move      = (state_reg == MOVE);
    assign ready     = (state_reg == PLAY);
    assign gameState = state_reg;

endmodule

// File: tb/tb_minesweeper_ctrl.sv
// Scoreboard bench for minesweeper_ctrl with a behavioural board model
// supplying per-cell states and the next cursor position.
module tb_minesweeper_ctrl;

    localparam int GS = 3;
    localparam int SS = 4;
    localparam int N  = GS * GS;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [N-1:0]  bombInit;
    logic          moveReq;
    logic [1:0]    moveDir;
    logic          revealReq;
    logic [SS*N-1:0] states;
    logic [N-1:0]  nextCursorGrid;
    logic [N-1:0]  bombGrid;
    logic [N-1:0]  revealGrid;
    logic [N-1:0]  cursorGrid;
    logic          move;
    logic [1:0]    dir;
    logic          ready;
    logic [2:0]    gameState;
    logic [7:0]    moveCount;

    typedef struct {
        int         cyc;
        logic [2:0] gs;
        logic [N-1:0] rev;
        logic [N-1:0] cur;
        logic [N-1:0] bomb;
        logic [7:0] mc;
        logic       mv;
        logic [1:0] dr;
    } exp_t;

    exp_t probe_q[$];
    exp_t settle_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    minesweeper_ctrl #(.GRID_SIZE(GS), .STATE_SIZE(SS)) dut (
        .clk(clk), .reset(reset), .start(start), .bombInit(bombInit),
        .moveReq(moveReq), .moveDir(moveDir), .revealReq(revealReq),
        .states(states), .nextCursorGrid(nextCursorGrid),
        .bombGrid(bombGrid), .revealGrid(revealGrid), .cursorGrid(cursorGrid),
        .move(move), .dir(dir), .ready(ready), .gameState(gameState),
        .moveCount(moveCount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic bit_at(input logic [N-1:0] v, input int idx);
        logic [N-1:0] t;
        t = v >> idx;
        return t[0];
    endfunction

    function automatic logic in_grid(input int r, input int c);
        return (r >= 0) && (r < GS) && (c >= 0) && (c < GS);
    endfunction

    // Board model: 9 marks a bomb, otherwise the count of bomb neighbours.
    function automatic logic [SS*N-1:0] board_states(input logic [N-1:0] b);
        logic [SS*N-1:0] s;
        logic [SS*N-1:0] v;
        int cnt;
        s = '0;
        for (int k = 0; k < N; k++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++)
                for (int dc = -1; dc <= 1; dc++)
                    if ((dr != 0 || dc != 0) && in_grid(k/GS + dr, k%GS + dc))
                        if (bit_at(b, (k/GS + dr)*GS + k%GS + dc)) cnt++;
            if (bit_at(b, k)) cnt = 9;
            v = '0;
            v[SS-1:0] = cnt[SS-1:0];
            s = s | (v << (k*SS));
        end
        return s;
    endfunction

    // right = lower index in the row, left = higher, up = +GS, down = -GS
    function automatic logic [N-1:0] board_next(input logic [N-1:0] cur, input logic [1:0] d);
        logic [N-1:0] res;
        logic [N-1:0] one;
        int r, c, nr, nc;
        res = '0;
        one = 1;
        for (int k = 0; k < N; k++) begin
            r = k / GS; c = k % GS; nr = r; nc = c;
            case (d)
                2'b00:   nc = c - 1;
                2'b01:   nr = r + 1;
                2'b10:   nc = c + 1;
                default: nr = r - 1;
            endcase
            if (bit_at(cur, k) && in_grid(nr, nc)) res = res | (one << (nr*GS + nc));
        end
        return res;
    endfunction

    assign states         = board_states(bombGrid);
    assign nextCursorGrid = board_next(cursorGrid, dir);

    function automatic exp_t mk(input int c, input logic [2:0] gs, input logic [N-1:0] rev,
                                input logic [N-1:0] cur, input logic [N-1:0] bomb,
                                input logic [7:0] mc, input logic mv, input logic [1:0] dr);
        exp_t x;
        x.cyc = c; x.gs = gs; x.rev = rev; x.cur = cur; x.bomb = bomb;
        x.mc = mc; x.mv = mv; x.dr = dr;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, expv);
        end
    endtask

    // Monitor: timed probes of in-flight states, plus one scoreboard entry per
    // arrival in a settled state (PLAY/WIN/LOSE).
    exp_t pe;
    exp_t se;
    logic [2:0] prev_gs = 3'd0;
    always @(negedge clk) begin
        if (probe_q.size() > 0 && probe_q[0].cyc == cyc) begin
            pe = probe_q.pop_front();
            chk("probe_gameState", 32'(gameState), 32'(pe.gs));
            chk("probe_revealGrid", 32'(revealGrid), 32'(pe.rev));
            chk("probe_cursorGrid", 32'(cursorGrid), 32'(pe.cur));
            chk("probe_move", 32'(move), 32'(pe.mv));
            chk("probe_dir", 32'(dir), 32'(pe.dr));
        end
        if (gameState != prev_gs && (gameState == 3'd1 || gameState == 3'd6 || gameState == 3'd7)) begin
            if (settle_q.size() == 0) begin
                chk("unexpected_settle_state", 32'(gameState), 32'hFFFF_FFFF);
            end else begin
                se = settle_q.pop_front();
                chk("settle_cycle", 32'(cyc), 32'(se.cyc));
                chk("settle_gameState", 32'(gameState), 32'(se.gs));
                chk("settle_revealGrid", 32'(revealGrid), 32'(se.rev));
                chk("settle_cursorGrid", 32'(cursorGrid), 32'(se.cur));
                chk("settle_bombGrid", 32'(bombGrid), 32'(se.bomb));
                chk("settle_moveCount", 32'(moveCount), 32'(se.mc));
                chk("settle_ready", 32'(ready), 32'(se.gs == 3'd1));
            end
        end
        prev_gs <= gameState;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_settled();
        int n;
        n = 0;
        while (!(gameState == 3'd1 || gameState == 3'd6 || gameState == 3'd7) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL settle_timeout: gameState=%0d, required PLAY/WIN/LOSE within 50 cycles", gameState);
        end
    endtask

    task automatic check_reset();
        chk("rst_gameState", 32'(gameState), 32'd0);
        chk("rst_bombGrid", 32'(bombGrid), 32'd0);
        chk("rst_revealGrid", 32'(revealGrid), 32'd0);
        chk("rst_cursorGrid", 32'(cursorGrid), 32'd0);
        chk("rst_moveCount", 32'(moveCount), 32'd0);
        chk("rst_move", 32'(move), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
    endtask

    task automatic do_start(input logic [N-1:0] b);
        start = 1'b1;
        bombInit = b;
        settle_q.push_back(mk(cyc + 1, 3'd1, 9'h000, 9'h001, b, 8'd0, 1'b0, 2'd0));
        tick();
        start = 1'b0;
        bombInit = '0;
        wait_settled();
        $display("start    bombs=0x%03h -> state=%0d cursor=0x%03h", b, gameState, cursorGrid);
    endtask

    task automatic do_move(input logic [1:0] d, input logic [N-1:0] rev, input logic [N-1:0] cur_before,
                           input logic [N-1:0] cur_after, input logic [N-1:0] bomb, input logic [7:0] mc,
                           input logic with_probe);
        int e;
        moveReq = 1'b1;
        moveDir = d;
        e = cyc + 1;
        if (with_probe) probe_q.push_back(mk(e, 3'd2, rev, cur_before, 9'h000, 8'd0, 1'b1, d));
        settle_q.push_back(mk(e + 1, 3'd1, rev, cur_after, bomb, mc, 1'b0, 2'd0));
        tick();
        moveReq = 1'b0;
        wait_settled();
        if (with_probe) $display("move     dir=%0d -> cursor=0x%03h count=%0d", d, cursorGrid, moveCount);
    endtask

    // Flood from a zero cell on an empty board: two sweeps, one idle sweep, CHECK, WIN.
    task automatic push_flood(input int e, input logic [N-1:0] cur, input logic [N-1:0] sweep1,
                              input logic [1:0] dr, input logic [7:0] mc);
        probe_q.push_back(mk(e,     3'd3, 9'h000, cur, 9'h000, 8'd0, 1'b0, dr));
        probe_q.push_back(mk(e + 1, 3'd4, cur,    cur, 9'h000, 8'd0, 1'b0, dr));
        probe_q.push_back(mk(e + 2, 3'd4, sweep1, cur, 9'h000, 8'd0, 1'b0, dr));
        probe_q.push_back(mk(e + 3, 3'd4, 9'h1FF, cur, 9'h000, 8'd0, 1'b0, dr));
        probe_q.push_back(mk(e + 4, 3'd5, 9'h1FF, cur, 9'h000, 8'd0, 1'b0, dr));
        settle_q.push_back(mk(e + 5, 3'd6, 9'h1FF, cur, 9'h000, mc, 1'b0, 2'd0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        reset = 1'b1; start = 1'b0; bombInit = '0;
        moveReq = 1'b0; moveDir = 2'b00; revealReq = 1'b0;
        tick(); tick();
        check_reset();
        $display("reset    state=%0d", gameState);
        reset = 1'b0;
        tick();

        // Empty board, reveal cell 0: flood to full board and win.
        do_start(9'h000);
        revealReq = 1'b1; e = cyc + 1;
        push_flood(e, 9'h001, 9'h01B, 2'd0, 8'd0);
        tick(); revealReq = 1'b0; wait_settled();
        $display("reveal   cell0 empty board -> state=%0d reveal=0x%03h", gameState, revealGrid);

        // Bomb at cell 1: cell 0 shows 1, no flood, back to PLAY.
        do_start(9'h002);
        revealReq = 1'b1; e = cyc + 1;
        probe_q.push_back(mk(e, 3'd3, 9'h000, 9'h001, 9'h000, 8'd0, 1'b0, 2'd0));
        probe_q.push_back(mk(e + 1, 3'd5, 9'h001, 9'h001, 9'h000, 8'd0, 1'b0, 2'd0));
        settle_q.push_back(mk(e + 2, 3'd1, 9'h001, 9'h001, 9'h002, 8'd0, 1'b0, 2'd0));
        tick(); revealReq = 1'b0; wait_settled();
        $display("reveal   cell0 next to bomb -> state=%0d reveal=0x%03h", gameState, revealGrid);

        // Move left onto the bomb and reveal it: LOSE with everything shown.
        do_move(2'b10, 9'h001, 9'h001, 9'h002, 9'h002, 8'd1, 1'b1);
        revealReq = 1'b1; e = cyc + 1;
        probe_q.push_back(mk(e, 3'd3, 9'h001, 9'h002, 9'h000, 8'd0, 1'b0, 2'd2));
        settle_q.push_back(mk(e + 1, 3'd7, 9'h1FF, 9'h002, 9'h002, 8'd1, 1'b0, 2'd0));
        tick(); revealReq = 1'b0; wait_settled();
        $display("reveal   bomb cell -> state=%0d reveal=0x%03h", gameState, revealGrid);

        // Steps off the edge are no-ops; a legal step up counts.
        do_start(9'h000);
        do_move(2'b00, 9'h000, 9'h001, 9'h001, 9'h000, 8'd0, 1'b1);
        do_move(2'b11, 9'h000, 9'h001, 9'h001, 9'h000, 8'd0, 1'b1);
        do_move(2'b01, 9'h000, 9'h001, 9'h008, 9'h000, 8'd1, 1'b1);

        // Reveal and move together: only the reveal happens (flood from cell 3).
        revealReq = 1'b1; moveReq = 1'b1; moveDir = 2'b10; e = cyc + 1;
        push_flood(e, 9'h008, 9'h0DB, 2'd1, 8'd1);
        tick(); revealReq = 1'b0; moveReq = 1'b0; wait_settled();
        $display("reveal+move cell3 -> state=%0d cursor=0x%03h count=%0d", gameState, cursorGrid, moveCount);

        // start pulse during FLOOD is ignored.
        do_start(9'h000);
        revealReq = 1'b1; e = cyc + 1;
        push_flood(e, 9'h001, 9'h01B, 2'd1, 8'd0);
        tick(); revealReq = 1'b0;
        tick();
        start = 1'b1; bombInit = 9'h100;
        tick(); start = 1'b0; bombInit = '0;
        wait_settled();
        $display("start during flood -> state=%0d bombs=0x%03h", gameState, bombGrid);

        // moveCount saturates at 255 (up/down oscillation between cells 0 and 3).
        do_start(9'h000);
        for (int i = 0; i < 258; i++) begin
            do_move((i % 2 == 0) ? 2'b01 : 2'b11, 9'h000,
                    (i % 2 == 0) ? 9'h001 : 9'h008,
                    (i % 2 == 0) ? 9'h008 : 9'h001,
                    9'h000, (i + 1 > 255) ? 8'd255 : 8'(i + 1), 1'b0);
        end
        $display("saturate 258 moves -> count=%0d", moveCount);

        // Reset in the middle of a flood.
        revealReq = 1'b1;
        tick(); revealReq = 1'b0;
        tick(); tick();
        chk("pre_reset_gameState", 32'(gameState), 32'd4);
        chk("pre_reset_revealGrid", 32'(revealGrid), 32'h01B);
        reset = 1'b1;
        #1;
        check_reset();
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_gameState", 32'(gameState), 32'd0);
        $display("reset mid-flood -> state=%0d reveal=0x%03h", gameState, revealGrid);
        do_start(9'h004);

        tick(); tick(); tick();
        chk("probe_queue_drained", 32'(probe_q.size()), 32'd0);
        chk("settle_queue_drained", 32'(settle_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
